// File: rtl/battle_pkg.sv
// Shared constants, type table and FSM encoding for the per-side battle resolver.
package battle_pkg;

    localparam int unsigned LOC_W     = 9;
    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned TOWER_SEL = 4;

    localparam logic [1:0] TYPE_NONE   = 2'b00;
    localparam logic [1:0] TYPE_LIGHT  = 2'b01;
    localparam logic [1:0] TYPE_MEDIUM = 2'b10;
    localparam logic [1:0] TYPE_HEAVY  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StDamage,
        StMove,
        StDone
    } state_e;

    function automatic logic [1:0] type_speed(input logic [1:0] t);
        case (t)
            TYPE_LIGHT:  return 2'd1;
            TYPE_MEDIUM: return 2'd2;
            TYPE_HEAVY:  return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic [7:0] type_hp(input logic [1:0] t);
        case (t)
            TYPE_LIGHT:  return 8'd20;
            TYPE_MEDIUM: return 8'd40;
            TYPE_HEAVY:  return 8'd80;
            default:     return 8'd0;
        endcase
    endfunction

    // Friendly units enter at the far end and march toward loc 0; enemies the reverse.
    function automatic logic [LOC_W-1:0] spawn_loc(input int unsigned side);
        return (side == 0) ? 9'd511 : 9'd0;
    endfunction

endpackage

// File: rtl/battle_resolver_free_slot_enc.sv
// Lowest-free-slot priority encoder over the 16-slot live mask.
module free_slot_enc
    import battle_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] i_live,
    output logic [3:0]           o_idx,
    output logic                 o_full
);

    always_comb begin
        o_idx = 4'd0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!i_live[i]) begin
                o_idx = 4'(i);
            end
        end
    end

    assign o_full = &i_live;

endmodule

// File: rtl/battle_resolver.sv
// Per-side unit store: spawns between frames, then one damage cycle and a 16-cycle move sweep.
module battle_resolver
    import battle_pkg::*;
#(
    parameter int unsigned SIDE     = 0,
    parameter int unsigned TOWER_HP = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_ack,
    output logic         o_done,
    input  logic [4:0]   i_dmg_sel,
    input  logic [7:0]   i_dmg_amt,
    input  logic [8:0]   i_opp_front,
    input  logic         i_spawn_req,
    input  logic [1:0]   i_spawn_type,
    output logic         o_spawn_ack,
    output logic         o_full,
    output logic [143:0] o_unit_loc,
    output logic [31:0]  o_unit_type,
    output logic [7:0]   o_tower_hp,
    output logic         o_tower_dead
);

    state_e           r_state;
    state_e           w_state_next;
    logic [LOC_W-1:0] r_loc  [NUM_SLOTS];
    logic [1:0]       r_type [NUM_SLOTS];
    logic [7:0]       r_hp   [NUM_SLOTS];
    logic [7:0]       r_tower_hp;
    logic [3:0]       r_idx;
    logic [4:0]       r_dmg_sel;
    logic [7:0]       r_dmg_amt;
    logic [8:0]       r_opp_front;
    logic             r_spawn_ack;

    logic [NUM_SLOTS-1:0] w_live;
    logic [3:0]           w_free_idx;
    logic                 w_full;
    logic                 w_latch;
    logic                 w_spawn;
    logic                 w_damage;
    logic                 w_move;
    logic [3:0]           w_dmg_slot;
    logic [LOC_W-1:0]     w_cur_loc;
    logic [9:0]           w_speed;
    logic [9:0]           w_sum;
    logic [LOC_W-1:0]     w_moved;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_bus
        assign w_live[g]              = (r_type[g] != TYPE_NONE);
        assign o_unit_loc[9*g +: 9]   = r_loc[g];
        assign o_unit_type[2*g +: 2]  = r_type[g];
    end

    free_slot_enc u_free_slot_enc (
        .i_live (w_live),
        .o_idx  (w_free_idx),
        .o_full (w_full)
    );

    assign o_full       = w_full;
    assign o_done       = (r_state == StDone);
    assign o_tower_hp   = r_tower_hp;
    assign o_tower_dead = (r_tower_hp == 8'd0);
    assign o_spawn_ack  = r_spawn_ack;
    assign w_dmg_slot   = r_dmg_sel[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_spawn      = 1'b0;
        w_damage     = 1'b0;
        w_move       = 1'b0;
        unique case (r_state)
            StIdle: begin
                // start has priority; a concurrent spawn waits until the frame is acked
                if (i_start) begin
                    w_latch      = 1'b1;
                    w_state_next = StDamage;
                end else if (i_spawn_req && (i_spawn_type != TYPE_NONE) && !w_full) begin
                    w_spawn = 1'b1;
                end
            end
            StDamage: begin
                w_damage     = 1'b1;
                w_state_next = StMove;
            end
            StMove: begin
                w_move = 1'b1;
                if (r_idx == 4'd15) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (i_ack) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // 10-bit arithmetic so stepping past 0 or 511 is caught before clamping.
    always_comb begin
        w_cur_loc = r_loc[r_idx];
        w_speed   = {8'd0, type_speed(r_type[r_idx])};
        w_moved   = w_cur_loc;
        if (SIDE == 0) begin
            w_sum = {1'b0, w_cur_loc} - w_speed;
            if (w_cur_loc > r_opp_front) begin
                if (w_sum[9] || (w_sum < {1'b0, r_opp_front})) begin
                    w_moved = r_opp_front;
                end else begin
                    w_moved = w_sum[8:0];
                end
            end
        end else begin
            w_sum = {1'b0, w_cur_loc} + w_speed;
            if (w_cur_loc < r_opp_front) begin
                if (w_sum > {1'b0, r_opp_front}) begin
                    w_moved = r_opp_front;
                end else begin
                    w_moved = w_sum[8:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                r_loc[i]  <= '0;
                r_type[i] <= TYPE_NONE;
                r_hp[i]   <= '0;
            end
            r_tower_hp  <= 8'(TOWER_HP);
            r_idx       <= '0;
            r_dmg_sel   <= '0;
            r_dmg_amt   <= '0;
            r_opp_front <= '0;
            r_spawn_ack <= 1'b0;
        end else begin
            r_spawn_ack <= w_spawn;
            if (w_latch) begin
                r_dmg_sel   <= i_dmg_sel;
                r_dmg_amt   <= i_dmg_amt;
                r_opp_front <= i_opp_front;
            end
            if (w_spawn) begin
                r_loc[w_free_idx]  <= spawn_loc(SIDE);
                r_type[w_free_idx] <= i_spawn_type;
                r_hp[w_free_idx]   <= type_hp(i_spawn_type);
            end
            if (w_damage) begin
                r_idx <= '0;
                if (r_dmg_sel[TOWER_SEL]) begin
                    r_tower_hp <= (r_tower_hp > r_dmg_amt) ? (r_tower_hp - r_dmg_amt) : 8'd0;
                end else if (r_type[w_dmg_slot] != TYPE_NONE) begin
                    if (r_hp[w_dmg_slot] <= r_dmg_amt) begin
                        r_type[w_dmg_slot] <= TYPE_NONE;
                        r_hp[w_dmg_slot]   <= 8'd0;
                    end else begin
                        r_hp[w_dmg_slot] <= r_hp[w_dmg_slot] - r_dmg_amt;
                    end
                end
            end
            if (w_move) begin
                r_idx <= r_idx + 4'd1;
                if (r_type[r_idx] != TYPE_NONE) begin
                    r_loc[r_idx] <= w_moved;
                end
            end
        end
    end

endmodule

// File: tb/tb_battle_resolver.sv
// Randomized scoreboard bench for both sides of battle_resolver against a reference model.
module tb_battle_resolver;

    localparam int KFrame = 0;
    localparam int KSpawn = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start      [2];
    logic         ack        [2];
    logic [4:0]   dmg_sel    [2];
    logic [7:0]   dmg_amt    [2];
    logic [8:0]   opp_front  [2];
    logic         spawn_req  [2];
    logic [1:0]   spawn_type [2];
    logic         done       [2];
    logic         spawn_ack  [2];
    logic         full       [2];
    logic         tower_dead [2];
    logic [143:0] unit_loc   [2];
    logic [31:0]  unit_type  [2];
    logic [7:0]   tower_hp   [2];

    battle_resolver #(.SIDE(0), .TOWER_HP(200)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start[0]), .i_ack(ack[0]), .o_done(done[0]),
        .i_dmg_sel(dmg_sel[0]), .i_dmg_amt(dmg_amt[0]), .i_opp_front(opp_front[0]),
        .i_spawn_req(spawn_req[0]), .i_spawn_type(spawn_type[0]),
        .o_spawn_ack(spawn_ack[0]), .o_full(full[0]), .o_unit_loc(unit_loc[0]),
        .o_unit_type(unit_type[0]), .o_tower_hp(tower_hp[0]), .o_tower_dead(tower_dead[0])
    );

    battle_resolver #(.SIDE(1), .TOWER_HP(200)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start[1]), .i_ack(ack[1]), .o_done(done[1]),
        .i_dmg_sel(dmg_sel[1]), .i_dmg_amt(dmg_amt[1]), .i_opp_front(opp_front[1]),
        .i_spawn_req(spawn_req[1]), .i_spawn_type(spawn_type[1]),
        .o_spawn_ack(spawn_ack[1]), .o_full(full[1]), .o_unit_loc(unit_loc[1]),
        .o_unit_type(unit_type[1]), .o_tower_hp(tower_hp[1]), .o_tower_dead(tower_dead[1])
    );

    typedef struct {
        int           side;
        int           kind;
        int           cyc;
        logic [31:0]  typ;
        logic [143:0] loc;
        logic [7:0]   tower;
        logic         full;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done [2] = '{1'b0, 1'b0};

    int m_type [2][16];
    int m_loc  [2][16];
    int m_hp   [2][16];
    int m_tower[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [143:0] act,
                                input logic [143:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic int hp_of(input int t);
        return (t == 1) ? 20 : (t == 2) ? 40 : (t == 3) ? 80 : 0;
    endfunction

    function automatic int speed_of(input int t);
        return (t == 1) ? 1 : (t == 2) ? 2 : (t == 3) ? 3 : 0;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                m_type[s][i] = 0;
                m_loc[s][i]  = 0;
                m_hp[s][i]   = 0;
            end
            m_tower[s] = 200;
        end
    endfunction

    function automatic int model_spawn(input int side, input int t);
        if (t == 0) return -1;
        for (int i = 0; i < 16; i++) begin
            if (m_type[side][i] == 0) begin
                m_type[side][i] = t;
                m_loc[side][i]  = (side == 0) ? 511 : 0;
                m_hp[side][i]   = hp_of(t);
                return i;
            end
        end
        return -1;
    endfunction

    function automatic void model_frame(input int side, input int sel, input int amt,
                                        input int opp);
        if (sel >= 16) begin
            m_tower[side] = (m_tower[side] > amt) ? m_tower[side] - amt : 0;
        end else if (m_type[side][sel] != 0) begin
            if (m_hp[side][sel] <= amt) begin
                m_type[side][sel] = 0;
                m_hp[side][sel]   = 0;
            end else begin
                m_hp[side][sel] -= amt;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (m_type[side][i] != 0) begin
                if (side == 0 && m_loc[side][i] > opp) begin
                    m_loc[side][i] -= speed_of(m_type[side][i]);
                    if (m_loc[side][i] < opp) m_loc[side][i] = opp;
                end else if (side == 1 && m_loc[side][i] < opp) begin
                    m_loc[side][i] += speed_of(m_type[side][i]);
                    if (m_loc[side][i] > opp) m_loc[side][i] = opp;
                end
            end
        end
    endfunction

    function automatic exp_t snapshot(input int side, input int kind, input int c);
        exp_t e;
        e.side  = side;
        e.kind  = kind;
        e.cyc   = c;
        e.full  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e.typ[2*i +: 2] = 2'(m_type[side][i]);
            e.loc[9*i +: 9] = 9'(m_loc[side][i]);
            if (m_type[side][i] == 0) e.full = 1'b0;
        end
        e.tower = 8'(m_tower[side]);
        return e;
    endfunction

    function automatic void check_event(input int s, input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event side=%0d kind=%0d actual=present required=none",
                     s, kind);
            return;
        end
        e = exp_q.pop_front();
        chk("event_source", 144'(s * 2 + kind), 144'(e.side * 2 + e.kind));
        chk("unit_type", unit_type[s], e.typ);
        chk("unit_loc", unit_loc[s], e.loc);
        if (kind == KFrame) begin
            chk("tower_hp", tower_hp[s], e.tower);
            chk("tower_dead", tower_dead[s], e.tower == 8'd0);
            chk("done_latency", cyc, e.cyc);
        end else begin
            chk("full_after_spawn", full[s], e.full);
        end
    endfunction

    // Monitor: decoupled from stimulus, consumes the scoreboard on every DUT event.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (done[s] === 1'b1 && !prev_done[s]) check_event(s, KFrame);
            if (spawn_ack[s] === 1'b1) check_event(s, KSpawn);
            prev_done[s] <= (done[s] === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int side);
        int n = 0;
        while (done[side] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done[side] !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout side=%0d actual=0 required=1", side);
        end
    endtask

    task automatic do_spawn(input int side, input int t);
        if (model_spawn(side, t) >= 0) exp_q.push_back(snapshot(side, KSpawn, 0));
        spawn_req[side]  = 1'b1;
        spawn_type[side] = 2'(t);
        tick();
        spawn_req[side]  = 1'b0;
        spawn_type[side] = 2'd0;
        tick();
    endtask

    task automatic do_frame(input int side, input int sel, input int amt, input int opp);
        model_frame(side, sel, amt, opp);
        exp_q.push_back(snapshot(side, KFrame, cyc + 18));
        start[side]     = 1'b1;
        dmg_sel[side]   = 5'(sel);
        dmg_amt[side]   = 8'(amt);
        opp_front[side] = 9'(opp);
        tick();
        start[side] = 1'b0;
        wait_done(side);
        tick();
        ack[side] = 1'b1;
        tick();
        ack[side] = 1'b0;
        chk("done_drop", done[side], 1'b0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start[s] = 0; ack[s] = 0; dmg_sel[s] = 0; dmg_amt[s] = 0; opp_front[s] = 0;
            spawn_req[s] = 0; spawn_type[s] = 0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("reset_type", unit_type[s], 32'd0);
            chk("reset_loc", unit_loc[s], 144'd0);
            chk("reset_tower", tower_hp[s], 8'd200);
            chk("reset_flags", {done[s], spawn_ack[s], full[s], tower_dead[s]}, 4'b0000);
        end

        // Three spawns, then slot kill plus first move, then tower overkill.
        do_spawn(0, 1);
        do_spawn(0, 2);
        do_spawn(0, 3);
        do_frame(0, 1, 40, 0);
        do_frame(0, 16, 250, 0);

        // Walk the heavy unit down to 13, then clamp at 12, 10, and hold at 10.
        while (m_loc[0][2] > 13) do_frame(0, 16, 0, 0);
        do_frame(0, 16, 0, 12);
        do_frame(0, 16, 0, 10);
        do_frame(0, 16, 0, 10);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_frame(0, int'($urandom_range(0, 31)),
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)),
                         int'($urandom_range(0, 511)));
            end else begin
                do_spawn(0, int'($urandom_range(0, 3)));
            end
        end

        // Reset while the move sweep is at index 7.
        start[0] = 1'b1;
        dmg_sel[0] = 5'd16;
        dmg_amt[0] = 8'd30;
        tick();
        start[0] = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midreset_type", unit_type[0], 32'd0);
        chk("midreset_tower", tower_hp[0], 8'd200);
        chk("midreset_done", done[0], 1'b0);

        for (int k = 0; k < 16; k++) do_spawn(0, int'($urandom_range(1, 3)));
        chk("full_set", full[0], 1'b1);
        do_spawn(0, 2);
        chk("full_no_ack", spawn_ack[0], 1'b0);

        // start and spawn together: frame first, spawn lands one edge after the ack edge.
        model_frame(0, 3, 255, 0);
        exp_q.push_back(snapshot(0, KFrame, cyc + 18));
        void'(model_spawn(0, 2));
        exp_q.push_back(snapshot(0, KSpawn, 0));
        start[0] = 1'b1; dmg_sel[0] = 5'd3; dmg_amt[0] = 8'd255; opp_front[0] = 9'd0;
        spawn_req[0] = 1'b1; spawn_type[0] = 2'd2;
        tick();
        start[0] = 1'b0;
        wait_done(0);
        tick();
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        chk("no_spawn_on_ack_edge", spawn_ack[0], 1'b0);
        tick();
        spawn_req[0] = 1'b0;
        spawn_type[0] = 2'd0;
        @(negedge clk);
        chk("spawn_after_ack", spawn_ack[0], 1'b1);
        tick();

        // Enemy side: march up, stall at 509, then clamp to 511 without wrapping.
        do_spawn(1, 3);
        while (m_loc[1][0] < 504) do_frame(1, 16, 0, 511);
        do_frame(1, 16, 0, 509);
        do_frame(1, 16, 0, 509);
        do_frame(1, 16, 0, 511);
        do_frame(1, 16, 0, 511);
        chk("enemy_final_loc", unit_loc[1][8:0], 9'd511);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
